// File: rtl/alu_pkg.sv
// Shared types and level-split helpers for the ALU shifter pipeline.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_LSR = 2'b00,
        OP_ASR = 2'b01,
        OP_LSL = 2'b10,
        OP_ROR = 2'b11
    } shift_op_t;

    function automatic int shift_levels(int width);
        return $clog2(width);
    endfunction

    // Mux levels are split evenly; leftover levels go to the earliest stages.
    function automatic int lvl_count(int levels, int stages, int s);
        return levels / stages + ((s < levels % stages) ? 1 : 0);
    endfunction

    function automatic int lvl_first(int levels, int stages, int s);
        return s * (levels / stages) + ((s < levels % stages) ? s : levels % stages);
    endfunction

endpackage

// File: rtl/barrel_shifter_pipe_stage.sv
// One pipeline slice of the shifter: COUNT right-shift mux levels plus a register.
// Rotate muxes are only built when SHIFTER_ROTATE_EN is defined.
module shift_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FIRST = 0,
    parameter int COUNT = 1,
    parameter bit LAST  = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     vld_d,
    input  shift_op_t                op_d,
    input  logic                     sat_d,
    input  logic [$clog2(WIDTH)-1:0] amt_d,
    input  logic                     sign_d,
    input  logic                     cy_d,
    input  logic [WIDTH-1:0]         data_d,
    output logic                     vld_q,
    output shift_op_t                op_q,
    output logic                     sat_q,
    output logic [$clog2(WIDTH)-1:0] amt_q,
    output logic                     sign_q,
    output logic                     cy_q,
    output logic [WIDTH-1:0]         data_q
);

    logic [WIDTH-1:0] data_nxt;
    logic             cy_nxt;

    always_comb begin
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] nd;
        logic             fill;
        int               k;
        d    = data_d;
        nd   = '0;
        cy_nxt = cy_d;
        k    = 0;
        fill = (op_d == OP_ASR) && sign_d;
        for (int i = 0; i < COUNT; i++) begin
            k = 1 << (FIRST + i);
            if (amt_d[FIRST+i]) begin
                // Last bit out of the highest set level is the overall carry.
                cy_nxt = d[k-1];
                for (int j = 0; j < WIDTH; j++) begin
                    if (j + k < WIDTH)
                        nd[j] = d[j+k];
`ifdef SHIFTER_ROTATE_EN
                    else if (op_d == OP_ROR)
                        nd[j] = d[j+k-WIDTH];
`endif
                    else
                        nd[j] = fill;
                end
                d = nd;
            end
        end
        if (LAST) begin
            if (sat_d) begin
                d      = {WIDTH{fill}};
                cy_nxt = fill;
            end
            if (op_d == OP_LSL)
                for (int j = 0; j < WIDTH; j++) nd[j] = d[WIDTH-1-j];
            else
                nd = d;
            d = nd;
        end
        data_nxt = d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            op_q   <= OP_LSR;
            sat_q  <= 1'b0;
            amt_q  <= '0;
            sign_q <= 1'b0;
            cy_q   <= 1'b0;
            data_q <= '0;
        end else if (en) begin
            vld_q  <= vld_d;
            op_q   <= op_d;
            sat_q  <= sat_d;
            amt_q  <= amt_d;
            sign_q <= sign_d;
            cy_q   <= cy_nxt;
            data_q <= data_nxt;
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (LSR/ASR/LSL/ROR) with valid/ready and a global stall.
// Define SHIFTER_ROTATE_EN to build ROR; otherwise op 11 behaves as LSR.
module barrel_shifter_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    localparam int LG = shift_levels(WIDTH);

    logic                        adv;
    logic [STAGES:0]             vld_pipe;
    shift_op_t                   op_p [STAGES:0];
    logic [STAGES:0]             sat_p;
    logic [STAGES:0]             sign_p;
    logic [STAGES:0]             cy_p;
    logic [STAGES:0][LG-1:0]     amt_p;
    logic [STAGES:0][WIDTH-1:0]  data_p;

    shift_op_t        op0;
    logic             sat0;
    logic [WIDTH-1:0] data0;
    logic             unused_tail;

    // LSL rides the right-shift muxes on bit-reversed data.
    always_comb begin
        op0 = shift_op_t'(op);
`ifndef SHIFTER_ROTATE_EN
        if (op0 == OP_ROR) op0 = OP_LSR;
`endif
        sat0 = |b[WIDTH-1:LG];
`ifdef SHIFTER_ROTATE_EN
        if (op0 == OP_ROR) sat0 = 1'b0;
`endif
        data0 = a;
        if (op0 == OP_LSL)
            for (int i = 0; i < WIDTH; i++) data0[i] = a[WIDTH-1-i];
    end

    assign adv         = !out_valid || out_ready;
    assign in_ready    = adv;
    assign vld_pipe[0] = in_valid;
    assign op_p[0]     = op0;
    assign sat_p[0]    = sat0;
    assign amt_p[0]    = b[LG-1:0];
    assign sign_p[0]   = a[WIDTH-1];
    assign cy_p[0]     = 1'b0;
    assign data_p[0]   = data0;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .FIRST (lvl_first(LG, STAGES, s)),
            .COUNT (lvl_count(LG, STAGES, s)),
            .LAST  (s == STAGES - 1)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .en     (adv),
            .vld_d  (vld_pipe[s]),
            .op_d   (op_p[s]),
            .sat_d  (sat_p[s]),
            .amt_d  (amt_p[s]),
            .sign_d (sign_p[s]),
            .cy_d   (cy_p[s]),
            .data_d (data_p[s]),
            .vld_q  (vld_pipe[s+1]),
            .op_q   (op_p[s+1]),
            .sat_q  (sat_p[s+1]),
            .amt_q  (amt_p[s+1]),
            .sign_q (sign_p[s+1]),
            .cy_q   (cy_p[s+1]),
            .data_q (data_p[s+1])
        );
    end

    assign out_valid = vld_pipe[STAGES];
    assign result    = data_p[STAGES];
    assign carry_out = cy_p[STAGES];
    // Gated by valid so the flag reads 0 out of reset and across bubbles.
    assign zero      = out_valid && (data_p[STAGES] == '0);

    assign unused_tail = ^{op_p[STAGES], sat_p[STAGES], amt_p[STAGES], sign_p[STAGES]};

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Pipelined, parametrised barrel shifter for the ALU datapath. It supports logical and arithmetic right shift, left shift and an optional rotate, with saturation for out-of-range shift amounts. It produces carry-out and zero flags. It sits between the operand-fetch register stage and ALU result writeback, with a valid/ready handshake on both sides so it can be stalled by writeback.

## Interface
Reset is synchronous and active-high on `rst`. All logic is clocked on the rising edge of `clk`.

Parameters:
- `WIDTH`, default 32: operand width. Must be a power of two, ≥ 4.
- `STAGES`, default 2: number of pipeline register stages, range 1..$clog2(WIDTH). This is also the latency.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  shifter accepts operands this cycle.
- `a`  in  WIDTH  data to shift.
- `b`  in  WIDTH  shift amount (full width, unsigned).
- `op`  in  2  shift operation code (encoding in shift_op_t):
  - 00 LSR
  - 01 ASR
  - 10 LSL
  - 11 ROR
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  WIDTH  shifted value.
- `carry_out`  out  1  last bit shifted out.
- `zero`  out  1  result == 0.

## Operation
- Effective amount `n`:
  - If `b[WIDTH-1:$clog2(WIDTH)] != 0`, the shift is saturated (`sat=1`).
  - Otherwise `n = b[$clog2(WIDTH)-1:0]`.
- LSR:
  - `sat` → result 0.
  - else `a >> n`, zero-filled.
- ASR:
  - `sat` → every bit = `a[WIDTH-1]`.
  - else `a >> n`, sign-filled.
- LSL:
  - `sat` → result 0.
  - else `a << n`, zero-filled.
- ROR: amount taken modulo WIDTH; `sat` is ignored.
- `carry_out`:
  - `n == 0` and not `sat` → 0.
  - LSR/ASR → `a[n-1]`.
  - LSL → `a[WIDTH-n]`.
  - ROR → `result[WIDTH-1]` when `b mod WIDTH != 0`, else 0.
  - `sat` → 0 for LSR/LSL, `a[WIDTH-1]` for ASR.
- `zero` is computed from the final result in the output stage.
- The $clog2(WIDTH) mux levels (shift by 1, 2, 4, …) are split as evenly as possible across `STAGES`. Any remainder levels go in the earlier stages.
- Each stage carries the following alongside its partial data:
  - valid bit
  - op
  - sat
  - remaining amount bits
  - a sign bit
  - pending carry

## Timing
- Latency: a beat accepted in cycle t appears on `out_valid`/`result` in cycle t+STAGES, when not stalled.
- Global enable: `adv = !out_valid || out_ready`, and `in_ready = adv`.
  - All stage registers load only when `adv = 1`.
  - Throughput is one beat per cycle.
- Transfers:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
  - A bubble (`in_valid=0` while `adv=1`) shifts a 0 valid bit into stage 1.
- While `out_valid && !out_ready`:
  - `result`, `carry_out` and `zero` hold stable.
  - `in_ready = 0`.
- Input transfer and output transfer in the same cycle are legal. The pipeline advances by one.
- Reset values:
  - `out_valid = 0`, `result = 0`, `carry_out = 0`, `zero = 0`.
  - All internal valid bits are 0.
  - `in_ready = 1` in the first cycle after reset.
- Reset mid-operation discards all in-flight beats. No output is produced for them.
- The block has no state machine beyond the per-stage valid bits.

## Configuration
- `SHIFTER_ROTATE_EN` defined: `op = 11` performs ROR as specified above.
- `SHIFTER_ROTATE_EN` undefined:
  - The rotate mux path is not compiled.
  - `op = 11` behaves exactly as LSR, including saturation and carry.

## Structure
- Package `alu_pkg`:
  - `shift_op_t` enum (LSR, ASR, LSL, ROR).
  - `function automatic int shift_levels(int width)` returning $clog2(width).
- Sub-module `shift_stage`, parametrised by WIDTH, first level index and level count:
  - Combinational mux levels plus one register slice with enable.
  - `barrel_shifter_pipe` instantiates `STAGES` of them in a generate loop.
- LSL is implemented as bit-reverse, LSR, bit-reverse, so each stage needs only right-shift muxes.

## Test plan
All scenarios use WIDTH=8, STAGES=2 unless stated otherwise.
- LSR `a=8'hB4`, `b=3`: `result=8'h16`, `carry_out=1`, `zero=0`, `out_valid` two cycles after acceptance.
- ASR `a=8'h90`, `b=200` (saturated): `result=8'hFF`, `carry_out=1`. LSL with the same operands: `result=8'h00`, `zero=1`, `carry_out=0`.
- LSL `a=8'h81`, `b=1`: `result=8'h02`, `carry_out=1`.
- ROR `a=8'h01`, `b=9`: `result=8'h80`, `carry_out=1` with `SHIFTER_ROTATE_EN`. Without the macro: `result=8'h00`, `carry_out=0`.
- Back-to-back beats with `out_ready` held low for 3 cycles:
  - No beat is lost or duplicated.
  - `result` stays stable while stalled.
  - `in_ready=0` during the stall.
  - Order is preserved.
  - Repeat with STAGES=1 and STAGES=3.
- Assert `rst` with 2 beats in flight: next cycle `out_valid=0`, `result=0`. Those beats never emerge.
